// File: rtl/fifo_push_arbiter_pkg.sv
// fifo_push_arbiter_pkg: shared types and helpers for the FIFO push arbiter.
// Rev 1.0
`default_nettype none

package fifo_push_arbiter_pkg;

  localparam int FIFO_DATA_WIDTH = 8;

  typedef logic [FIFO_DATA_WIDTH-1:0] data_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Round-robin successor of idx in a ring of n slots.
  function automatic int unsigned rr_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if: producer-side requests and FIFO write-side signals.
// Rev 1.0
`default_nettype none

interface fifo_push_arbiter_if
  import fifo_push_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_push;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;
  logic                          busy;
  logic [IDX_W-1:0]              owner_id;

  modport master (
    output req, data, fifo_full,
    input  gnt, fifo_push, fifo_data_in, busy, owner_id
  );

  modport slave (
    input  req, data, fifo_full,
    output gnt, fifo_push, fifo_data_in, busy, owner_id
  );

endinterface

`default_nettype wire

// File: rtl/fifo_push_arbiter_rr_pick.sv
// fifo_push_arbiter_rr_pick: first requester at or after rr_ptr, modulo NUM_REQ.
// Rev 1.0
`default_nettype none

module fifo_push_arbiter_rr_pick
  import fifo_push_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] i_req,
  input  wire logic [IDX_W-1:0]   i_rr_ptr,
  output logic                    o_found,
  output logic [IDX_W-1:0]        o_idx
);

  int w_j;

  // Scan farthest offset first so the closest requester to rr_ptr wins last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = (int'(i_rr_ptr) + k) % NUM_REQ;
      if (i_req[w_j]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(w_j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin, burst-bounded sharing of one FIFO push port.
// Rev 1.0
`default_nettype none

module fifo_push_arbiter
  import fifo_push_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int MAX_BURST  = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  fifo_push_arbiter_if.slave io_bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  arb_state_e             r_state;
  arb_state_e             w_state_nxt;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [IDX_W-1:0]       w_rr_ptr_nxt;
  logic [IDX_W-1:0]       r_owner;
  logic [IDX_W-1:0]       w_owner_nxt;
  logic [CNT_W-1:0]       r_burst_cnt;
  logic [CNT_W-1:0]       w_burst_cnt_nxt;
  logic                   w_found;
  logic [IDX_W-1:0]       w_pick;
  logic                   w_push;
  logic [NUM_REQ-1:0]     w_gnt;
  logic [IDX_W-1:0]       w_owner_inc;
  logic [DATA_WIDTH-1:0]  w_owner_data;

  fifo_push_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req    (io_bus.req),
    .i_rr_ptr (r_rr_ptr),
    .o_found  (w_found),
    .o_idx    (w_pick)
  );

  assign w_owner_inc  = IDX_W'(rr_inc(32'(r_owner), NUM_REQ));
  assign w_owner_data = io_bus.data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_owner_nxt     = r_owner;
    w_burst_cnt_nxt = r_burst_cnt;
    w_push          = 1'b0;
    w_gnt           = '0;
    case (r_state)
      IDLE: begin
        if (w_found && !io_bus.fifo_full) begin
          w_owner_nxt     = w_pick;
          w_burst_cnt_nxt = '0;
          w_state_nxt     = BURST;
        end
      end
      BURST: begin
        // Suppressed under reset so the in-flight word stays with its producer.
        w_push = io_bus.req[r_owner] & ~io_bus.fifo_full & ~rst;
        if (w_push) begin
          w_gnt[r_owner]  = 1'b1;
          w_burst_cnt_nxt = r_burst_cnt + CNT_W'(1);
          if (r_burst_cnt == CNT_W'(MAX_BURST - 1)) begin
            w_state_nxt  = IDLE;
            w_rr_ptr_nxt = w_owner_inc;
          end
        end else if (!io_bus.req[r_owner]) begin
          w_state_nxt  = IDLE;
          w_rr_ptr_nxt = w_owner_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign io_bus.gnt          = w_gnt;
  assign io_bus.fifo_push    = w_push;
  assign io_bus.fifo_data_in = w_owner_data;
  assign io_bus.busy         = (r_state == BURST);
  assign io_bus.owner_id     = r_owner;

endmodule

`default_nettype wire
